// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes
// and controller state encodings, kept beside the ALU op codes.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Magnitudes are iterated one bit per cycle; sign correction happens in FIX.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  md_state_e            state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;     // product, or {remainder, quotient}
  logic [WIDTH-1:0]     opnd_q, opnd_d;   // multiplicand or divisor magnitude
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_q, neg_d;     // negate product / quotient
  logic                 rneg_q, rneg_d;   // negate remainder
  logic                 dz_q, dz_d;
  logic                 div_q, div_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, done_q;

  logic                 in_div, in_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       add_sum, rem_sh, sub_diff;

  assign in_div    = op[1];
  assign in_signed = ~op[0];
  assign a_neg     = in_signed & a[WIDTH-1];
  assign b_neg     = in_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply adds into the upper word with carry; divide trial-subtracts the
  // shifted partial remainder, whose top bit needs the extra position.
  assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign sub_diff = rem_sh - {1'b0, opnd_q};

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      MD_IDLE, MD_DONE: begin
        if (start) begin
          dz_d    = in_div && (b == '0);
          div_d   = in_div;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          opnd_d  = b_mag;
          // Divide by zero keeps the raw dividend so HI can return it untouched.
          acc_d   = {{WIDTH{1'b0}}, (in_div && (b == '0)) ? a : a_mag};
          cnt_d   = '0;
          state_d = (in_div && (b == '0)) ? MD_FIX : MD_CALC;
        end else begin
          state_d = MD_IDLE;
          if (state_q == MD_IDLE) begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
          end
        end
      end

      MD_CALC: begin
        if (div_q) begin
          if (sub_diff[WIDTH]) acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          else                 acc_d = {sub_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          if (acc_q[0]) acc_d = {add_sum, acc_q[WIDTH-1:1]};
          else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = MD_FIX;
      end

      MD_FIX: begin
        if (dz_q) begin
          lo_d = '1;
          hi_d = acc_q[WIDTH-1:0];
        end else if (div_q) begin
          lo_d = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
          hi_d = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
        state_d = MD_DONE;
      end

      default: state_d = MD_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so a mid-operation reset leaves no stale partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      div_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= (state_d == MD_CALC) || (state_d == MD_FIX);
      done_q  <= (state_d == MD_DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: an arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {HI, LO} from plain 64-bit arithmetic on the operands.
  function automatic logic [63:0] ref_result(input logic [1:0] f_op,
                                             input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f_op)
      2'b00:   return 64'(sx * sy);
      2'b01:   return ux * uy;
      default: begin
        if (y == '0)        return {x, 32'hFFFF_FFFF};
        else if (f_op == 2'b10) return {32'(sx % sy), 32'(sx / sy)};
        else                return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  // Model: elapsed cycles since an accepted start, the fixed latency, and
  // the HI/LO contents as architecturally visible.
  bit           m_active = 1'b0;
  int           m_t      = 0;
  int           m_lat    = 0;
  logic [W-1:0] m_hi     = '0;
  logic [W-1:0] m_lo     = '0;
  logic [63:0]  m_res    = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_lat    <= 0;
      m_hi     <= '0;
      m_lo     <= '0;
    end else if (m_active && m_t < m_lat) begin
      m_t <= m_t + 1;
      if (m_t + 1 == m_lat) {m_hi, m_lo} <= m_res;
    end else if (start) begin
      m_res    <= ref_result(op, a, b);
      m_lat    <= (op[1] && b == '0) ? 2 : 34;
      m_t      <= 1;
      m_active <= 1'b1;
    end else begin
      if (!m_active) begin
        if (hi_we) m_hi <= wdata;
        if (lo_we) m_lo <= wdata;
      end
      m_active <= 1'b0;
    end
  end

  always @(negedge clk) begin
    check("model_busy", busy, m_active && m_t < m_lat);
    check("model_done", done, m_active && m_t == m_lat);
    check("model_hi", hi, m_hi);
    check("model_lo", lo, m_lo);
  end

  // Called on a falling edge; returns on the falling edge of the done cycle.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input int lat, input logic [W-1:0] ehi, input logic [W-1:0] elo);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    if (lat > 2) check({name, "_busy1"}, busy, 1);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, lat);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    @(negedge clk);

    // Back-to-back: each start lands in the previous operation's done cycle.
    run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'd7,         34, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min",  MD_MULT,  32'h8000_0000, 32'h8000_0000, 34, 32'h4000_0000, 32'h0000_0000);
    run_op("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'd2,         34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb",  MD_DIV,   32'd7,         32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu",      MD_DIVU,  32'd100,       32'd7,         34, 32'd2,         32'd14);
    run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000);
    run_op("div_zero",  MD_DIV,   32'h0000_1234, 32'd0,         2,  32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_zneg",  MD_DIV,   32'hFFFF_FFF9, 32'd0,         2,  32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("divu_zero", MD_DIVU,  32'd5,         32'd0,         2,  32'd5,         32'hFFFF_FFFF);

    // MTHI in the done cycle is dropped.
    hi_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_in_done", hi, 32'd5);

    // Start during cycle 10 and MTHI while busy are both ignored.
    start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    repeat (9) begin @(negedge clk); n++; end
    start = 1'b1; op = MD_DIVU; a = 32'd1; b = 32'd1; hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    n++;
    start = 1'b0; hi_we = 1'b0;
    while (!done && n < 60) begin @(negedge clk); n++; end
    check("ignore_latency", n, 34);
    check("ignore_hi", hi, 0);
    check("ignore_lo", lo, 15);

    // MTHI in IDLE lands on the next edge.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAA;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_idle", hi, 32'hAA);

    // Start beats a simultaneous MTLO.
    lo_we = 1'b1; wdata = 32'h77;
    run_op("start_wins", MD_MULTU, 32'd2, 32'd3, 34, 32'd0, 32'd6);
    lo_we = 1'b0;
    @(negedge clk);

    // Reset in cycle 15 of a divide clears everything at once.
    start = 1'b1; op = MD_DIV; a = 32'h0123_4567; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_hi", hi, 0);
    check("midreset_lo", lo, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_reset", MD_MULTU, 32'd3, 32'd5, 34, 32'd0, 32'd15);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/muldiv.md
# muldiv

Iterative multiply/divide unit for the multicycle MIPS core, placed in the EXE stage beside the ALU. It consumes a start strobe and an operation code from the multicycle controller together with the two register-file read values. It computes MULT, MULTU, DIV and DIVU into architectural HI/LO registers over a fixed number of cycles. While the unit is working it raises `busy`, which the controller uses to hold in EXE. HI/LO are exposed for MFHI/MFLO and are writable for MTHI/MTLO.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin operation `op` on `a`, `b`; honoured only when idle.
- `op` in 2: operation code; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a` in WIDTH: rs value, the multiplicand or dividend.
- `b` in WIDTH: rt value, the multiplier or divisor.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; HI/LO hold the new result.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: 32 iterations, counter 0..31.
  - FIX: applies sign correction and writes HI/LO.
  - DONE: one cycle, pulses `done`.
- IDLE transitions:
  - `start`=1 latches `a`, `b`, `op` and goes to CALC.
  - For signed ops the unit stores the magnitudes |a| and |b| plus the sign bits.
  - `b`==0 with DIV/DIVU goes straight to FIX with the div-by-zero flag set.
- CALC, multiply: radix-2 shift-add on magnitudes, one bit per cycle, producing a 2·WIDTH-bit product.
- CALC, divide: restoring division on magnitudes, one quotient bit per cycle.
- CALC exits to FIX after iteration 31.
- FIX, MULT: the 64-bit product is negated if sign(a)^sign(b). HI = upper word, LO = lower word.
- FIX, DIV: the quotient is negated if sign(a)^sign(b), and the remainder is negated if sign(a). LO = quotient, HI = remainder.
- Unsigned ops apply no sign correction.
- Divide by zero, fixed behaviour for both DIV and DIVU: LO = all ones, HI = `a` unchanged.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000 (wraps) and HI = 0. No trap is raised.
- `start` while `busy`: ignored. There is no queueing.
- `hi_we`/`lo_we` in IDLE: the register is written at the next edge.
- `hi_we`/`lo_we` while busy or in DONE: ignored.
- `start` together with `hi_we`/`lo_we` in IDLE: `start` wins and the write is dropped.
- Reset, at any time including mid-operation: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, internal accumulators and counter cleared.

## Timing
- Cycle 0: IDLE with `start`=1; `busy`=0 in this cycle.
- Cycles 1–32: CALC with `busy`=1.
- Cycle 33: FIX with `busy`=1; HI/LO load at the end of this cycle.
- Cycle 34: DONE with `done`=1, `busy`=0, new HI/LO visible. The next `start` is accepted in this cycle.
- Latency from `start` to `done` is 34 cycles for every non-zero-divisor operation.
- Divide by zero: FIX in cycle 1, `done` in cycle 2.
- `busy`, `done`, `hi` and `lo` are all registered outputs with no combinational path from inputs.
- HI/LO keep their old values throughout CALC and FIX, so MFHI during `busy` returns the stale value. The controller must stall MFHI/MFLO while `busy`=1.

## Structure
- The op codes (MD_MULT/MD_MULTU/MD_DIV/MD_DIVU) and state encodings go in the shared control encode-definitions include, next to the ALU op codes.
- Single module; there is no natural sub-module.
- The negate/absolute-value logic is inline combinational logic, used at latch time and in FIX.
- The iteration counter is 5 bits.
- The datapath registers are:
  - a 2·WIDTH-bit product/remainder register
  - a WIDTH-bit multiplicand/divisor register
  - sign flags
  - the div-by-zero flag.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `done` at cycle 34; HI=0xFFFFFFFE, LO=0x00000001; `busy` high for cycles 1–33.
- MULT 0xFFFFFFFD (−3) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 → LO=14, HI=2. DIV 0x80000000 / −1 → LO=0x80000000, HI=0.
- DIV 0x1234 / 0 → `done` at cycle 2, LO=0xFFFFFFFF, HI=0x1234.
- `start` during cycle 10 of a MULT → ignored, original result unchanged. `hi_we`=1, `wdata`=0xAA during busy → HI not written. `hi_we`=1 in IDLE → HI=0xAA next cycle.
- `rst_n` low at cycle 15 of a DIV → `busy`, `done`, `hi` and `lo` read 0 immediately. After release, a fresh MULTU 3 × 5 gives LO=15, HI=0 at cycle 34.
